// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// sync_fifo_if : request/response bundle between a FIFO user and sync_fifo
// Rev 1.0
// ============================================================================
interface sync_fifo_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          clear;
  logic          write;
  logic [DW-1:0] din;
  logic          read;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] data_cnt;
  logic          overflow;
  logic          underflow;

  modport master (
    output clear, write, din, read,
    input  dout, full, empty, almost_full, almost_empty, data_cnt, overflow, underflow
  );

  modport slave (
    input  clear, write, din, read,
    output dout, full, empty, almost_full, almost_empty, data_cnt, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO, any DEPTH >= 2, registered or FWFT read data
// Rev 1.0
// ============================================================================
module sync_fifo #(
  parameter int DW     = 8,
  parameter int DEPTH  = 8,
  parameter int FWFT   = 0,
  parameter int AF_THR = DEPTH - 1,
  parameter int AE_THR = 1
) (
  input  wire        clk,
  input  wire        rst_n,
  sync_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);
  localparam logic [CW-1:0] c_af    = CW'(AF_THR);
  localparam logic [CW-1:0] c_ae    = CW'(AE_THR);
  localparam logic [PW-1:0] c_last  = PW'(DEPTH - 1);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be >= 2");
    end
    if (AF_THR < 1 || AF_THR > DEPTH) begin : g_bad_af
      $error("sync_fifo: AF_THR must be within 1..DEPTH");
    end
    if (AE_THR < 0 || AE_THR > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo: AE_THR must be within 0..DEPTH-1");
    end
  endgenerate

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          full, empty, rd_acc, wr_acc;

  assign full   = (cnt_q == c_depth);
  assign empty  = (cnt_q == '0);
  assign rd_acc = bus.read & ~empty;
  // A read on the same edge frees the slot, so a write while full still lands.
  assign wr_acc = bus.write & (~full | rd_acc);

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = inc_ptr(wr_ptr_q);
      if (rd_acc) rd_ptr_d = inc_ptr(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      if (bus.write & ~wr_acc) ovf_d = 1'b1;
      if (bus.read & empty)    unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !bus.clear) mem_q[wr_ptr_q] <= bus.din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DW-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = dout_q;
        if (bus.clear)   dout_d = '0;
        else if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
      end

      assign bus.dout = dout_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (cnt_q >= c_af);
  assign bus.almost_empty = (cnt_q <= c_ae);
  assign bus.data_cnt     = cnt_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo : three FIFO variants driven in lockstep, checked against a
// queue model every cycle. Rev 1.0
// ============================================================================
module tb_sync_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       clear_s = 1'b0;
  logic       write_s = 1'b0;
  logic       read_s  = 1'b0;
  logic [7:0] din_s   = 8'h00;

  sync_fifo_if #(.DW(8), .DEPTH(5)) b0 ();
  sync_fifo_if #(.DW(8), .DEPTH(8)) b1 ();
  sync_fifo_if #(.DW(8), .DEPTH(8)) b2 ();

  assign b0.clear = clear_s;  assign b0.write = write_s;  assign b0.din = din_s;  assign b0.read = read_s;
  assign b1.clear = clear_s;  assign b1.write = write_s;  assign b1.din = din_s;  assign b1.read = read_s;
  assign b2.clear = clear_s;  assign b2.write = write_s;  assign b2.din = din_s;  assign b2.read = read_s;

  sync_fifo #(.DW(8), .DEPTH(5), .FWFT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  sync_fifo #(.DW(8), .DEPTH(8), .FWFT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  sync_fifo #(.DW(8), .DEPTH(8), .FWFT(0), .AF_THR(6), .AE_THR(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  // Per-variant configuration of the model.
  localparam int DEP [3] = '{5, 8, 8};
  localparam int FW  [3] = '{0, 1, 0};
  localparam int AFT [3] = '{4, 7, 6};
  localparam int AET [3] = '{1, 1, 2};

  logic [7:0] mq [3][$];
  logic [7:0] mdreg [3];
  logic       movf [3];
  logic       munf [3];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mdreg[i] = 8'h00;
      movf[i]  = 1'b0;
      munf[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    int   n;
    logic rd_ok, wr_ok;
    logic [7:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      n = mq[i].size();
      if (clear_s) begin
        mq[i].delete();
        mdreg[i] = 8'h00;
        movf[i]  = 1'b0;
        munf[i]  = 1'b0;
      end else begin
        rd_ok = read_s && (n > 0);
        wr_ok = write_s && ((n < DEP[i]) || rd_ok);
        if (read_s && n == 0) munf[i] = 1'b1;
        if (write_s && !wr_ok) movf[i] = 1'b1;
        if (rd_ok) begin
          w = mq[i].pop_front();
          if (FW[i] == 0) mdreg[i] = w;
        end
        if (wr_ok) mq[i].push_back(din_s);
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] a_dout, a_cnt, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [31:0] e_dout;
    int n;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin
          a_dout = 32'(b0.dout); a_cnt = 32'(b0.data_cnt); a_full = 32'(b0.full); a_empty = 32'(b0.empty);
          a_af = 32'(b0.almost_full); a_ae = 32'(b0.almost_empty); a_ovf = 32'(b0.overflow); a_unf = 32'(b0.underflow);
        end
        1: begin
          a_dout = 32'(b1.dout); a_cnt = 32'(b1.data_cnt); a_full = 32'(b1.full); a_empty = 32'(b1.empty);
          a_af = 32'(b1.almost_full); a_ae = 32'(b1.almost_empty); a_ovf = 32'(b1.overflow); a_unf = 32'(b1.underflow);
        end
        default: begin
          a_dout = 32'(b2.dout); a_cnt = 32'(b2.data_cnt); a_full = 32'(b2.full); a_empty = 32'(b2.empty);
          a_af = 32'(b2.almost_full); a_ae = 32'(b2.almost_empty); a_ovf = 32'(b2.overflow); a_unf = 32'(b2.underflow);
        end
      endcase
      n = mq[i].size();
      if (FW[i] != 0) e_dout = (n > 0) ? 32'(mq[i][0]) : 32'h0;
      else            e_dout = 32'(mdreg[i]);
      chk($sformatf("u%0d.dout", i),         a_dout,  e_dout);
      chk($sformatf("u%0d.data_cnt", i),     a_cnt,   32'(n));
      chk($sformatf("u%0d.full", i),         a_full,  32'(n == DEP[i]));
      chk($sformatf("u%0d.empty", i),        a_empty, 32'(n == 0));
      chk($sformatf("u%0d.almost_full", i),  a_af,    32'(n >= AFT[i]));
      chk($sformatf("u%0d.almost_empty", i), a_ae,    32'(n <= AET[i]));
      chk($sformatf("u%0d.overflow", i),     a_ovf,   32'(movf[i]));
      chk($sformatf("u%0d.underflow", i),    a_unf,   32'(munf[i]));
    end
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, check.
  task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r);
    clear_s = c;
    write_s = w;
    din_s   = d;
    read_s  = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("areset.u0.empty", 32'(b0.empty), 32'd1);
    chk("areset.u0.dout",  32'(b0.dout), 32'h0);
    chk("areset.u2.cnt",   32'(b2.data_cnt), 32'd0);
    step(1'b0, 1'b1, 8'h77, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("rst.u0.empty", 32'(b0.empty), 32'd1);
    chk("rst.u0.ae",    32'(b0.almost_empty), 32'd1);
    chk("rst.u1.dout",  32'(b1.dout), 32'h0);
    rst_n = 1'b1;

    // Fill past capacity on the 5-deep variant.
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, 8'(8'h11 + k), 1'b0);
      if (k == 4) chk("fill.u0.full5", 32'(b0.full), 32'd1);
    end
    chk("fill.u0.ovf", 32'(b0.overflow), 32'd1);
    chk("fill.u0.cnt", 32'(b0.data_cnt), 32'd5);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (k < 5) chk($sformatf("drain.u0.dout%0d", k), 32'(b0.dout), 32'(8'h11 + k));
    end
    chk("drain.u0.unf",   32'(b0.underflow), 32'd1);
    chk("drain.u0.empty", 32'(b0.empty), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Pointer wrap: three rounds of 4 in / 4 out.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("wrap.u0.cnt_up", 32'(b0.data_cnt), 32'(k + 1));
      end
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap.u0.cnt_dn", 32'(b0.data_cnt), 32'(3 - k));
      end
    end

    // Simultaneous read/write when full, then when empty.
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    chk("rw_full.u0.cnt",  32'(b0.data_cnt), 32'd5);
    chk("rw_full.u0.full", 32'(b0.full), 32'd1);
    chk("rw_full.u0.ovf",  32'(b0.overflow), 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b1);
    chk("rw_empty.u0.cnt", 32'(b0.data_cnt), 32'd1);
    chk("rw_empty.u0.unf", 32'(b0.underflow), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // First-word-fall-through.
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    chk("fwft.u1.empty", 32'(b1.empty), 32'd0);
    chk("fwft.u1.dout",  32'(b1.dout), 32'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fwft.u1.empty_after", 32'(b1.empty), 32'd1);
    chk("fwft.u1.dout_after",  32'(b1.dout), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0);

    // Thresholds on the 8-deep AF=6/AE=2 variant.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 8'($urandom), 1'b0);
      if (k == 4) chk("thr.u2.af_at5", 32'(b2.almost_full), 32'd0);
      if (k == 5) chk("thr.u2.af_at6", 32'(b2.almost_full), 32'd1);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (k == 4) chk("thr.u2.ae_at3", 32'(b2.almost_empty), 32'd0);
      if (k == 5) chk("thr.u2.ae_at2", 32'(b2.almost_empty), 32'd1);
    end

    // Clear wins over a simultaneous write, with both sticky flags set.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr.u0.cnt_before", 32'(b0.data_cnt), 32'd3);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("clr.u0.cnt",   32'(b0.data_cnt), 32'd0);
    chk("clr.u0.empty", 32'(b0.empty), 32'd1);
    chk("clr.u0.ovf",   32'(b0.overflow), 32'd0);
    chk("clr.u0.unf",   32'(b0.underflow), 32'd0);

    // Asynchronous reset mid-cycle with data stored.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'(8'h60 + k), 1'b0);
    async_reset_pulse();

    // Randomized traffic, with occasional clear and one reset mid-stream.
    for (int it = 0; it < 600; it++) begin
      int wp;
      wp = (it / 100) % 2 == 0 ? 70 : 30;
      if (it == 300) async_reset_pulse();
      step(1'b0 | ($urandom_range(99) < 2), $urandom_range(99) < wp,
           8'($urandom), $urandom_range(99) >= wp);
    end

    // After a reset the first accepted write is the first word read.
    async_reset_pulse();
    step(1'b0, 1'b1, 8'h99, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst.u0.dout", 32'(b0.dout), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DW, 8: data width in bits.
- DEPTH, 8: number of entries; any integer >= 2, not limited to powers of two.
- FWFT, 0: 0 = standard (registered) read mode; 1 = first-word-fall-through mode.
- AF_THR, DEPTH-1: almost_full threshold.
- AE_THR, 1: almost_empty threshold.
REQ-002 Elaboration SHALL fail if DEPTH<2, AF_THR outside 1..DEPTH, or AE_THR outside 0..DEPTH-1.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- clear, in, 1: synchronous flush.
- write, in, 1: write request.
- din, in, DW: write data.
- read, in, 1: read request.
- dout, out, DW: read data.
- full, out, 1: no free entry.
- empty, out, 1: no stored entry.
- almost_full, out, 1: data_cnt >= AF_THR.
- almost_empty, out, 1: data_cnt <= AE_THR.
- data_cnt, out, $clog2(DEPTH+1): stored entry count.
- overflow, out, 1: sticky, set by a write attempted while full.
- underflow, out, 1: sticky, set by a read attempted while empty.

Function
REQ-004 A write SHALL be accepted when write=1 and full=0 at a clk edge; din is stored at wr_ptr, and wr_ptr advances.
REQ-005 A read SHALL be accepted when read=1 and empty=0 at a clk edge; rd_ptr advances.
REQ-006 wr_ptr and rd_ptr SHALL wrap from DEPTH-1 to 0 for any DEPTH, including non-powers of two.
REQ-007 data_cnt SHALL change by +1 on an accepted write only, -1 on an accepted read only, and 0 when both are accepted or neither is; it never exceeds DEPTH.
REQ-008 The flags SHALL be derived from the registered data_cnt (see the sketch after this section):
- full = (data_cnt==DEPTH)
- empty = (data_cnt==0)
- almost_full = (data_cnt>=AF_THR)
- almost_empty = (data_cnt<=AE_THR)
REQ-009 Read and write in the same cycle while full SHALL accept both; the read frees an entry and the write reuses it, so data_cnt stays DEPTH.
REQ-010 Read and write in the same cycle while empty SHALL accept only the write; there is no bypass, and underflow is set.
REQ-011 A write while full that is not accompanied by an accepted read SHALL be dropped and set overflow; memory and pointers are unchanged.
REQ-012 A read while empty SHALL be dropped and set underflow.
REQ-013 overflow and underflow SHALL stay set until reset or clear.
REQ-014 With FWFT=0, an accepted read SHALL load mem[rd_ptr] into the dout register on that edge (data visible one cycle after read); dout holds its value otherwise.
REQ-015 With FWFT=1, dout SHALL equal mem[rd_ptr] combinationally whenever empty=0, and 0 when empty=1. An accepted read exposes the next word after the edge.
REQ-016 With FWFT=1, a word written into an empty FIFO SHALL appear on dout, with empty=0, in the cycle after the write edge.
REQ-017 clear=1 SHALL take priority over write and read in the same cycle. On that edge: pointers and data_cnt go to 0, overflow and underflow go to 0, and dout goes to 0 (FWFT=0). Memory contents need not be cleared.
REQ-018 Memory SHALL be a register array with no reset requirement on its contents.

Sketch (informative): data_cnt <= data_cnt + wr_acc - rd_acc; wr_acc = write & (~full | rd_acc); rd_acc = read & ~empty.

Reset
REQ-019 When rst_n=0, the block SHALL immediately, without waiting for clk, set the following:
- pointers = 0, data_cnt = 0
- dout = 0, empty = 1, full = 0
- almost_empty = 1, almost_full = 0
- overflow = 0, underflow = 0
REQ-020 Reset asserted mid-operation SHALL discard all stored entries; the first accepted write after release is the first word read.
REQ-021 Deassertion of rst_n SHALL be synchronised externally; the block samples no request on the edge on which rst_n is seen low.

Verification
REQ-022 Fill/drain test, DW=8, DEPTH=5, FWFT=0: write 7 words (0x11..0x17) back-to-back.
- Required: 0x11..0x15 stored, full=1 after the 5th write, overflow=1.
- Then 6 reads: dout = 0x11..0x15, each one cycle after its read; underflow=1; empty=1.
REQ-023 Wrap-around test, DEPTH=5: run 3 rounds of write 4 / read 4.
- Required: data order preserved across the pointer wrap; data_cnt follows 0..4..0 each round.
REQ-024 Simultaneous read/write test, DEPTH=5:
- When full, read+write together: data_cnt stays 5, full stays 1, no overflow.
- When empty, read+write together: data_cnt=1, underflow=1.
REQ-025 FWFT test, FWFT=1, DEPTH=8: write 0xA5 into the empty FIFO.
- Required: the next cycle shows empty=0 and dout=0xA5 with no read issued.
- A read then gives empty=1 and dout=0.
REQ-026 Threshold test, DEPTH=8, AF_THR=6, AE_THR=2: fill to 8, then drain.
- Required: almost_full=1 exactly when data_cnt>=6.
- Required: almost_empty=1 exactly when data_cnt<=2.
REQ-027 Clear/reset test: with 3 words stored and flags set, assert clear together with write.
- Required: data_cnt=0, empty=1, overflow=0, underflow=0, and the write is ignored.
- Repeat using asynchronous rst_n asserted mid-cycle: all outputs take their reset values immediately, without a clk edge.
